// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for an unsigned M x N multiply. It
// time-shares one external combinational 4 x N multiplier: operand A is split
// into 4-bit digits, one digit goes out per pass, and after SETTLE wait cycles
// the partial product is shifted into place and accumulated.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   start_valid/ready  request handshake carrying a_in (M bits), b_in (N bits)
//   mul_a, mul_b       registered digit / operand driven to the multiplier
//   mul_p              multiplier product (N+4 bits), sampled on accumulate edges
//   done_valid/ready   result handshake; product (M+N bits) is valid with done_valid
//   busy               high while in RUN or DONE
//   state_dbg          current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source must hold valid and data stable until that edge; the
// sink may assert ready independently of valid.
module mult_seq_ctrl #(
  parameter int N      = 16,
  parameter int M      = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [M-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic [3:0]       mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [N+3:0]     mul_p,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [M+N-1:0]   product,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int D     = M / 4;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int PW    = M + N;

  if (N < 2) begin : g_bad_n
    $error("mult_seq_ctrl: N must be >= 2");
  end
  if ((M % 4) != 0 || M < 4) begin : g_bad_m
    $error("mult_seq_ctrl: M must be a multiple of 4 and >= 4");
  end
  if (SETTLE < 0) begin : g_bad_settle
    $error("mult_seq_ctrl: SETTLE must be >= 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [M-1:0]       a_reg;
  logic [N-1:0]       b_reg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      acc;

  logic [PW-1:0]      pp;
  logic [IDX_W-1:0]   idx_nxt;
  logic               last_digit;

  // Partial product for the current digit, moved to its digit position.
  // M >= 4 guarantees the zero-extension never truncates mul_p.
  assign pp         = PW'(mul_p) << {idx, 2'b00};
  assign idx_nxt    = idx + IDX_W'(1);
  assign last_digit = (idx == IDX_W'(D - 1));

  assign mul_b      = b_reg;
  assign product    = acc;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      done_valid  <= 1'b0;
      busy        <= 1'b0;
      mul_a       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      idx         <= '0;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            mul_a       <= a_in[3:0];
            idx         <= '0;
            cnt         <= CNT_W'(SETTLE);
            acc         <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            // Multiplier array still settling on the current digit.
            cnt <= cnt - CNT_W'(1);
          end else begin
            acc <= acc + pp;
            if (last_digit) begin
              done_valid <= 1'b1;
              state      <= DONE;
            end else begin
              idx   <= idx_nxt;
              mul_a <= a_reg[{idx_nxt, 2'b00} +: 4];
              cnt   <= CNT_W'(SETTLE);
            end
          end
        end
        DONE: begin
          // start_valid is ignored here; requests never overlap.
          if (done_ready) begin
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a 16x16 / SETTLE=1 instance driven through a
// one-cycle-latency multiplier model, and an 8x4 / SETTLE=0 instance with a
// purely combinational multiplier model.
module tb_mult_seq_ctrl;

  localparam int S   = 1;
  localparam int LAT = 4 * (S + 1);   // D = 4 digits
  localparam int LAT_S = 2;           // D = 2 digits, SETTLE = 0

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1: M=16 N=16 SETTLE=1 ----------------
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [3:0]  mul_a;
  logic [15:0] mul_b;
  logic [19:0] mul_p = '0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [31:0] product;
  logic        busy;
  logic [1:0]  state_dbg;

  // Slow multiplier: the product of the driven operands appears one edge later.
  always @(posedge clk) mul_p <= mul_a * mul_b;

  mult_seq_ctrl #(.N(16), .M(16), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .done_valid(done_valid), .done_ready(done_ready),
    .product(product), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- instance 2: M=8 N=4 SETTLE=0 ----------------
  logic        start_valid_s = 1'b0;
  logic        start_ready_s;
  logic [7:0]  a_in_s = '0;
  logic [3:0]  b_in_s = '0;
  logic [3:0]  mul_a_s;
  logic [3:0]  mul_b_s;
  logic [7:0]  mul_p_s;
  logic        done_valid_s;
  logic        done_ready_s = 1'b0;
  logic [11:0] product_s;
  logic        busy_s;
  logic [1:0]  state_dbg_s;

  assign mul_p_s = mul_a_s * mul_b_s;

  mult_seq_ctrl #(.N(4), .M(8), .SETTLE(0)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid_s), .start_ready(start_ready_s),
    .a_in(a_in_s), .b_in(b_in_s),
    .mul_a(mul_a_s), .mul_b(mul_b_s), .mul_p(mul_p_s),
    .done_valid(done_valid_s), .done_ready(done_ready_s),
    .product(product_s), .busy(busy_s), .state_dbg(state_dbg_s)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [11:0] exp_q_s[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // One full request on instance 1; 'hold' cycles of done_ready=0 backpressure
  // with start_valid pulsing before the product is consumed.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    int k;
    logic [31:0] exp_p;
    logic [31:0] held;
    k = 0;
    while (!start_ready && k < 50) begin
      tick();
      k++;
    end
    check("start_ready_before_req", start_ready, 1'b1);
    a_in = a;
    b_in = b;
    start_valid = 1'b1;
    exp_q.push_back(32'(a) * 32'(b));
    tick();
    start_valid = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    check("busy_after_accept", busy, 1'b1);
    check("start_ready_in_run", start_ready, 1'b0);
    check("mul_a_digit0", mul_a, a[3:0]);
    check("mul_b_operand", mul_b, b);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      check("done_valid_timing", done_valid, (c == LAT));
      if (c < LAT) check("mul_a_digit", mul_a, 4'(a >> (4 * (c / (S + 1)))));
    end
    check("state_done", state_dbg, 2'd2);
    held = product;
    for (int c = 0; c < hold; c++) begin
      start_valid = c[0];
      a_in = 16'($urandom);
      tick();
      check("bp_done_valid", done_valid, 1'b1);
      check("bp_product_stable", product, held);
      check("bp_start_ready", start_ready, 1'b0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    check("exp_q_not_empty", exp_q.size() > 0, 1'b1);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("product", product, exp_p);
    tick();
    done_ready = 1'b0;
    check("done_valid_cleared", done_valid, 1'b0);
    check("start_ready_idle", start_ready, 1'b1);
    check("busy_idle", busy, 1'b0);
    check("product_hold_idle", product, exp_p);
  endtask

  task automatic run_op_s(input logic [7:0] a, input logic [3:0] b);
    logic [11:0] exp_p;
    check("s_start_ready", start_ready_s, 1'b1);
    a_in_s = a;
    b_in_s = b;
    start_valid_s = 1'b1;
    exp_q_s.push_back(12'(a) * 12'(b));
    tick();
    start_valid_s = 1'b0;
    check("s_mul_a_digit0", mul_a_s, a[3:0]);
    for (int c = 1; c <= LAT_S; c++) begin
      tick();
      check("s_done_valid_timing", done_valid_s, (c == LAT_S));
      if (c < LAT_S) check("s_mul_a_digit1", mul_a_s, a[7:4]);
    end
    exp_p = (exp_q_s.size() > 0) ? exp_q_s.pop_front() : 12'hBAD;
    check("s_product", product_s, exp_p);
    done_ready_s = 1'b1;
    tick();
    done_ready_s = 1'b0;
    check("s_done_valid_cleared", done_valid_s, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit seen_done;
    rst_n = 1'b0;
    start_valid = 1'($urandom);
    done_ready = 1'($urandom);
    tick();
    tick();
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, 32'h0);
    check("rst_mul_a", mul_a, 4'h0);
    check("rst_mul_b", mul_b, 16'h0);
    check("rst_state", state_dbg, 2'd0);
    start_valid = 1'b0;
    done_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h0005, 0);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'h0000, 16'hABCD, 0);
    run_op(16'hBEEF, 16'h1357, 5);
    // The edge that returns to IDLE is followed directly by a new accept.
    run_op(16'h0F0F, 16'h8001, 0);
    for (int i = 0; i < 4; i++)
      run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             $urandom_range(0, 3));

    // Abort in the middle of RUN.
    a_in = 16'h4321;
    b_in = 16'h1111;
    start_valid = 1'b1;
    exp_q.push_back(32'h4321 * 32'h1111);
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    check("abort_start_ready", start_ready, 1'b1);
    check("abort_done_valid", done_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_product", product, 32'h0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_valid) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 1'b0);
    run_op(16'd7, 16'd9, 0);

    // SETTLE=0 instance.
    run_op_s(8'hAB, 4'hF);
    run_op_s(8'h00, 4'hF);
    run_op_s(8'hFF, 4'hF);
    for (int i = 0; i < 3; i++)
      run_op_s(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller that computes an M-bit × N-bit unsigned product by time-sharing one external combinational 4×N multiplier (multiplier4xN2). It slices operand A into 4-bit digits, drives one digit per pass, and waits a programmable number of settle cycles for the slow combinational array. It then captures the partial product and shift-accumulates it. It sits between a valid/ready request source and the multiplier instance, and owns all operand and result registers.

## Interface
- N, 16, width of operand B and of the multiplier's B port; must be ≥ 2.
- M, 16, width of operand A; must be a multiple of 4 and ≥ 4. Digit count D = M/4.
- SETTLE, 1, wait cycles after driving a digit before capturing mul_p; must be ≥ 0.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  controller can accept a request.
- a_in  input  M  operand A.
- b_in  input  N  operand B.
- mul_a  output  4  digit driven to the multiplier A port (registered).
- mul_b  output  N  operand driven to the multiplier B port (registered).
- mul_p  input  N+4  multiplier product.
- done_valid  output  1  product is valid.
- done_ready  input  1  consumer accepts the product.
- product  output  M+N  result, equal to a_in × b_in.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - A_reg (M).
  - B_reg (N).
  - digit index idx (ceil(log2 D), minimum 1 bit).
  - settle counter cnt (range 0..SETTLE).
  - accumulator acc (M+N), which drives product.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: latch A_reg←a_in, B_reg←b_in, mul_a←a_in[3:0], mul_b←b_in, idx←0, cnt←SETTLE, acc←0; go to RUN.
- RUN:
  - start_ready = 0.
  - If cnt ≠ 0: cnt←cnt−1; nothing else changes.
  - If cnt = 0: acc←acc + (zero-extend(mul_p) << 4·idx).
    - If idx = D−1: go to DONE.
    - Otherwise: idx←idx+1, mul_a←A_reg[4·(idx+1)+:4], cnt←SETTLE.
- DONE:
  - done_valid = 1.
  - product holds.
  - start_valid is ignored.
  - On done_ready: go to IDLE.
- Requests never overlap; there is no pipelining across requests.
- Width rules:
  - All arithmetic is unsigned.
  - The shifted partial product is truncated to M+N bits.
  - The final sum never exceeds 2^(M+N)−1, so acc never overflows.
- product, mul_a and mul_b hold their last values in IDLE until the next accept.
- Zero digits are not skipped; latency is data-independent.
- Parameter violations (N<2, M%4≠0, M<4, SETTLE<0) raise $error at elaboration.

## Timing
- Reset: any edge with rst_n=0 forces the following, regardless of state:
  - state→IDLE.
  - start_ready=1, done_valid=0, busy=0.
  - mul_a=0, mul_b=0, acc/product=0.
  - idx=0, cnt=0.
- Reset mid-RUN or mid-DONE aborts the operation; no done_valid is produced for the aborted request.
- Accept edge = edge T with start_valid && start_ready.
- mul_a and mul_b carry digit 0 from T.
- Each digit occupies SETTLE+1 cycles: SETTLE wait cycles, then one accumulate edge.
- done_valid rises after the edge at T + D·(SETTLE+1).
  - With M=16, SETTLE=1: 8 cycles.
  - With SETTLE=0: D cycles.
- Output handshake:
  - If done_ready is high while done_valid is high, the next edge returns the controller to IDLE.
  - start_ready is high again one cycle after the product is consumed.
  - The minimum request spacing is D·(SETTLE+1)+2 cycles.
- mul_p is sampled only on accumulate edges. SETTLE must cover the multiplier's propagation delay in clock periods.

## Test plan
- Reset: hold rst_n=0 for 2 edges in random state → start_ready=1, done_valid=0, busy=0, product=0, mul_a=0, mul_b=0.
- M=16, N=16, SETTLE=1; a_in=0x1234, b_in=0x0005 → mul_a sequence 4, 3, 2, 1, each held 2 cycles; done_valid 8 cycles after accept; product=0x00005B04.
- Max operands: a_in=0xFFFF, b_in=0xFFFF → product=0xFFFE0001, no overflow.
- Backpressure: hold done_ready=0 for 5 cycles while pulsing start_valid → done_valid stays 1, product stable, start_ready=0; assert done_ready → IDLE next edge, new request accepted the edge after.
- Reset mid-operation: drop rst_n at cycle 3 of RUN → IDLE next edge, done_valid never rises; a following request with a_in=7, b_in=9 → product=63.
- SETTLE=0, M=8, N=4: a_in=0xAB, b_in=0xF → done_valid 2 cycles after accept, product=0xA05; a_in=0, b_in=0xF → product=0.
